// File: rtl/misc_commit_unit.sv
// Commit end of the misc pipe: buffers writeback entries and applies their CSR, TLB and
// redirect side effects in ROB order before signalling retirement.
`ifndef PROC_VALEN
`define PROC_VALEN 32
`endif

module misc_commit_unit #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned ROB_IDX_W = 6,
  localparam int unsigned VaW      = `PROC_VALEN,
  localparam int unsigned EntryW   = ROB_IDX_W + 102 + 2 * VaW,
  localparam int unsigned WbW      = EntryW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  // {valid, rob_idx, we, wdata, csr_we, csr_waddr, csr_wdata, br_inst, br_redirect,
  //  br_target, priv_instr, priv_op, invtlb_op, invtlb_asid, invtlb_vaddr}, MSB first
  input  logic [WbW-1:0]       wb_i,
  output logic                 wb_ready_o,
  input  logic                 rob_head_valid_i,
  input  logic [ROB_IDX_W-1:0] rob_head_idx_i,
  output logic                 csr_we_o,
  output logic [13:0]          csr_waddr_o,
  output logic [31:0]          csr_wdata_o,
  output logic                 tlb_req_valid_o,
  output logic [3:0]           tlb_req_op_o,
  output logic [4:0]           tlb_req_invop_o,
  output logic [9:0]           tlb_req_asid_o,
  output logic [VaW-1:0]       tlb_req_vaddr_o,
  input  logic                 tlb_ready_i,
  output logic                 redirect_valid_o,
  output logic [VaW-1:0]       redirect_target_o,
  output logic                 retire_valid_o,
  output logic [ROB_IDX_W-1:0] retire_rob_idx_o,
  output logic                 retire_we_o,
  output logic [31:0]          retire_wdata_o
);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic                 we;
    logic [31:0]          wdata;
    logic                 csr_we;
    logic [13:0]          csr_waddr;
    logic [31:0]          csr_wdata;
    logic                 br_inst;
    logic                 br_redirect;
    logic [VaW-1:0]       br_target;
    logic                 priv_instr;
    logic [3:0]           priv_op;
    logic [4:0]           invtlb_op;
    logic [9:0]           invtlb_asid;
    logic [VaW-1:0]       invtlb_vaddr;
  } entry_t;

  localparam logic [3:0] OpTlbSrch = 4'd1;
  localparam logic [3:0] OpTlbRd   = 4'd2;
  localparam logic [3:0] OpTlbWr   = 4'd3;
  localparam logic [3:0] OpTlbFill = 4'd4;
  localparam logic [3:0] OpInvTlb  = 4'd5;

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StExec, StTlb, StRetire} state_e;

  state_e          state_q, state_d;
  entry_t          mem_q [BUF_DEPTH];
  entry_t          mem_d [BUF_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  entry_t wb_entry, head;
  logic   wb_valid, push, pop, nonempty, head_match, is_tlb;

  assign wb_valid   = wb_i[WbW-1];
  assign wb_entry   = wb_i[EntryW-1:0];
  assign wb_ready_o = (cnt_q != CntW'(BUF_DEPTH));
  assign push       = wb_valid & wb_ready_o;
  assign pop        = (state_q == StRetire);
  assign nonempty   = (cnt_q != '0);
  assign head       = mem_q[rptr_q];
  assign head_match = nonempty & rob_head_valid_i & (rob_head_idx_i == head.rob_idx);
  assign is_tlb     = head.priv_instr &
                      ((head.priv_op == OpTlbSrch) | (head.priv_op == OpTlbRd) |
                       (head.priv_op == OpTlbWr)   | (head.priv_op == OpTlbFill) |
                       (head.priv_op == OpInvTlb));

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wb_entry;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (head_match) state_d = StExec;
      StExec:   state_d = is_tlb ? StTlb : StRetire;
      StTlb:    if (tlb_ready_i) state_d = StRetire;
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    csr_we_o          = 1'b0;
    csr_waddr_o       = '0;
    csr_wdata_o       = '0;
    tlb_req_valid_o   = 1'b0;
    tlb_req_op_o      = '0;
    tlb_req_invop_o   = '0;
    tlb_req_asid_o    = '0;
    tlb_req_vaddr_o   = '0;
    redirect_valid_o  = 1'b0;
    redirect_target_o = '0;
    retire_valid_o    = 1'b0;
    retire_rob_idx_o  = '0;
    retire_we_o       = 1'b0;
    retire_wdata_o    = '0;
    unique case (state_q)
      StExec: begin
        csr_we_o          = head.csr_we;
        csr_waddr_o       = head.csr_waddr;
        csr_wdata_o       = head.csr_wdata;
        redirect_valid_o  = head.br_inst & head.br_redirect;
        redirect_target_o = head.br_target;
      end
      StTlb: begin
        tlb_req_valid_o = 1'b1;
        tlb_req_op_o    = head.priv_op;
        tlb_req_invop_o = head.invtlb_op;
        tlb_req_asid_o  = head.invtlb_asid;
        tlb_req_vaddr_o = head.invtlb_vaddr;
      end
      StRetire: begin
        retire_valid_o   = 1'b1;
        retire_rob_idx_o = head.rob_idx;
        retire_we_o      = head.we;
        retire_wdata_o   = head.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
